// File: rtl/test_pattern_gen.sv
// test_pattern_gen: five-pattern RGB test source with a 2-clock pipeline and frame-aligned switching.
// Define TEST_PATTERN_ANIM_EN to scroll patterns 1, 2 and 4 by a per-frame offset.
module test_pattern_gen #(
    parameter int H_RESOLUTION      = 640,
    parameter int V_RESOLUTION      = 480,
    parameter bit H_SYNC_POLARITY   = 1'b0,
    parameter bit V_SYNC_POLARITY   = 1'b0,
    parameter int CHECKER_LOG2      = 5,
    parameter int RAMP_SHIFT        = 1,
    parameter int AUTO_CYCLE_FRAMES = 0
) (
    input  logic               i_pixel_clk,
    input  logic               i_reset_n,
    input  logic [2:0]         i_hvesync,
    input  logic               i_frame_start,
    input  logic signed [12:0] i_x,
    input  logic signed [12:0] i_y,
    input  logic               i_next_pattern,
    output logic [2:0]         o_hvesync,
    output logic [23:0]        o_rgb,
    output logic [2:0]         o_pattern
);
    localparam int BAR_W = H_RESOLUTION / 8;
    localparam int XW = ((CHECKER_LOG2 > RAMP_SHIFT + 7) ? CHECKER_LOG2 : RAMP_SHIFT + 7) + 1;
    localparam int CW = (AUTO_CYCLE_FRAMES > 1) ? $clog2(AUTO_CYCLE_FRAMES) : 1;
    localparam logic [2:0] HV_IDLE = {1'b0, !V_SYNC_POLARITY, !H_SYNC_POLARITY};
    localparam logic [23:0] BAR_RGB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic [2:0]    pattern;
    logic          pending;
    logic [CW-1:0] frame_cnt;
    logic          auto_adv;
    logic          advance;
    logic [XW-1:0] x_anim;
    logic [2:0]    bar;
    logic [2:0]    s1_hv;
    logic [2:0]    s1_pattern;
    logic [2:0]    s1_bar;
    logic          s1_checker;
    logic [7:0]    s1_ramp;
    logic          s1_border;
    logic          s1_grid;
    logic [23:0]   colour;

    assign auto_adv  = (AUTO_CYCLE_FRAMES > 0) && (frame_cnt == CW'(AUTO_CYCLE_FRAMES - 1));
    assign advance   = i_frame_start & (pending | i_next_pattern | auto_adv);
    assign o_pattern = pattern;

    // Requests only ever land on a frame start, so a frame never mixes two patterns.
    always_ff @(posedge i_pixel_clk) begin
        if (!i_reset_n) begin
            pattern   <= '0;
            pending   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (advance) begin
                pattern   <= (pattern == 3'd4) ? 3'd0 : pattern + 3'd1;
                frame_cnt <= '0;
            end else if (i_frame_start) begin
                frame_cnt <= frame_cnt + CW'(1);
            end
            pending <= i_frame_start ? 1'b0 : (pending | i_next_pattern);
        end
    end

`ifdef TEST_PATTERN_ANIM_EN
    logic [7:0] offset;
    always_ff @(posedge i_pixel_clk) begin
        if (!i_reset_n) offset <= '0;
        else if (i_frame_start) offset <= offset + 8'd1;
    end
    assign x_anim = XW'(i_x) + XW'(offset);
`else
    assign x_anim = XW'(i_x);
`endif

    always_comb begin
        bar = '0;
        for (int k = 1; k < 8; k++) if (int'(i_x) >= k * BAR_W) bar = 3'(k);
    end

    always_ff @(posedge i_pixel_clk) begin
        if (!i_reset_n) begin
            s1_hv      <= HV_IDLE;
            s1_pattern <= '0;
            s1_bar     <= '0;
            s1_checker <= 1'b0;
            s1_ramp    <= '0;
            s1_border  <= 1'b0;
            s1_grid    <= 1'b0;
        end else begin
            s1_hv      <= i_hvesync;
            s1_pattern <= pattern;
            s1_bar     <= bar;
            s1_checker <= x_anim[CHECKER_LOG2] ^ i_y[CHECKER_LOG2];
            s1_ramp    <= x_anim[RAMP_SHIFT+7:RAMP_SHIFT];
            s1_border  <= (i_x == '0) || (i_x == 13'(H_RESOLUTION - 1)) ||
                          (i_y == '0) || (i_y == 13'(V_RESOLUTION - 1));
            s1_grid    <= (x_anim[4:0] == 5'd0) || (i_y[4:0] == 5'd0);
        end
    end

    always_comb begin
        colour = (s1_pattern == 3'd0) ? BAR_RGB[s1_bar] :
                 (s1_pattern == 3'd1) ? (s1_checker ? 24'hFFFFFF : 24'h000000) :
                 (s1_pattern == 3'd2) ? {3{s1_ramp}} :
                 (s1_pattern == 3'd3) ? (s1_border ? 24'hFFFFFF : 24'h000000) :
                 (s1_grid ? 24'h00FF00 : 24'h202020);
    end

    always_ff @(posedge i_pixel_clk) begin
        if (!i_reset_n) begin
            o_hvesync <= HV_IDLE;
            o_rgb     <= '0;
        end else begin
            o_hvesync <= s1_hv;
            o_rgb     <= s1_hv[2] ? colour : 24'h000000;
        end
    end
endmodule

// File: tb/tb_test_pattern_gen.sv
// tb_test_pattern_gen: random stimulus against an arithmetic reference model, scoreboard-checked.
module tb_test_pattern_gen;
    localparam int H = 640, V = 480, CL = 5, RS = 1, AUTO = 2;
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    typedef struct {int due; logic [2:0] hv; logic [23:0] rgb;} px_t;
    typedef struct {int due; int pat;} pt_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [2:0]         hv = 3'b011;
    logic               fs = 1'b0;
    logic signed [12:0] x = '0;
    logic signed [12:0] y = '0;
    logic               np = 1'b0;
    logic [2:0]         o_hv;
    logic [23:0]        o_rgb;
    logic [2:0]         o_pat;

    px_t pxq[$];
    pt_t ptq[$];
    int  checks = 0, passes = 0;
    int  m_pat = 0, m_pend = 0, m_fcnt = 0, m_off = 0, drv_edge = 0;

    always #5 clk = ~clk;

    test_pattern_gen #(.H_RESOLUTION(H), .V_RESOLUTION(V), .H_SYNC_POLARITY(1'b0),
                       .V_SYNC_POLARITY(1'b0), .CHECKER_LOG2(CL), .RAMP_SHIFT(RS),
                       .AUTO_CYCLE_FRAMES(AUTO)) dut (
        .i_pixel_clk(clk), .i_reset_n(rst_n), .i_hvesync(hv), .i_frame_start(fs),
        .i_x(x), .i_y(y), .i_next_pattern(np),
        .o_hvesync(o_hv), .o_rgb(o_rgb), .o_pattern(o_pat));

    function automatic logic [23:0] ref_rgb(int p, int xv, int yv, int off);
        int xa;
        int g;
        xa = xv + off;
        g = (xa >> RS) % 256;
        case (p)
            0: return BARS[xv / (H / 8)];
            1: return (((xa >> CL) ^ (yv >> CL)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
            2: return {g[7:0], g[7:0], g[7:0]};
            3: return (xv == 0 || xv == H - 1 || yv == 0 || yv == V - 1) ? 24'hFFFFFF : 24'h000000;
            default: return (xa % 32 == 0 || yv % 32 == 0) ? 24'h00FF00 : 24'h202020;
        endcase
    endfunction

    task automatic cyc(bit r, bit de, int xv, int yv, bit f, bit n);
        logic [1:0] s;
        int off;
        s = 2'($urandom);
        rst_n = r; fs = f; np = n; hv = {de, s}; x = 13'(xv); y = 13'(yv);
`ifdef TEST_PATTERN_ANIM_EN
        off = m_off;
`else
        off = 0;
`endif
        if (!r) begin
            pxq.delete();
            pxq.push_back('{drv_edge, 3'b011, 24'h0});
            pxq.push_back('{drv_edge + 1, 3'b011, 24'h0});
            ptq.push_back('{drv_edge, 0});
            m_pat = 0; m_pend = 0; m_fcnt = 0; m_off = 0;
        end else begin
            pxq.push_back('{drv_edge + 1, {de, s}, de ? ref_rgb(m_pat, xv, yv, off) : 24'h0});
            if (f) begin
                if (m_pend != 0 || n || (AUTO > 0 && m_fcnt == AUTO - 1)) begin
                    m_pat = (m_pat + 1) % 5;
                    m_fcnt = 0;
                end else m_fcnt++;
                m_pend = 0;
                m_off = (m_off + 1) % 256;
            end else if (n) m_pend = 1;
            ptq.push_back('{drv_edge, m_pat});
        end
        @(negedge clk);
        drv_edge++;
    endtask

    task automatic chk(string name, int k, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s edge %0d: got %0h expected %0h", name, k, got, exp);
    endtask

    initial begin
        int k = 0;
        forever begin
            @(posedge clk);
            #1;
            while (pxq.size() > 0 && pxq[0].due < k) begin
                chk("px_missed", k, 32'(pxq[0].due), 32'(k));
                pxq.delete(0);
            end
            if (pxq.size() > 0 && pxq[0].due == k) begin
                chk("hvesync", k, 32'(o_hv), 32'(pxq[0].hv));
                chk("rgb", k, 32'(o_rgb), 32'(pxq[0].rgb));
                pxq.delete(0);
            end
            while (ptq.size() > 0 && ptq[0].due < k) begin
                chk("pat_missed", k, 32'(ptq[0].due), 32'(k));
                ptq.delete(0);
            end
            if (ptq.size() > 0 && ptq[0].due == k) begin
                chk("pattern", k, 32'(o_pat), 32'(ptq[0].pat));
                ptq.delete(0);
            end
            k++;
        end
    end

    initial begin
        repeat (3) cyc(0, 0, -1, -1, 0, 0);
        cyc(1, 1, 80, 10, 0, 0);
        cyc(1, 1, 639, 10, 0, 0);
        cyc(1, 0, -5, 10, 0, 0);
        cyc(1, 1, 100, 20, 0, 1);
        cyc(1, 1, 101, 20, 0, 0);
        cyc(1, 1, 102, 20, 0, 1);
        cyc(1, 1, 103, 20, 0, 1);
        cyc(1, 0, -3, -2, 1, 0);
        cyc(1, 0, -2, -2, 0, 0);
        cyc(1, 1, 32, 0, 0, 0);
        cyc(1, 1, 32, 32, 0, 0);
        cyc(1, 1, 0, 479, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit de;
            de = ($urandom_range(0, 3) != 0);
            if (i >= 1500 && i < 1503) cyc(0, de, 10, 10, 0, 0);
            else if (de) cyc(1, 1, $urandom_range(0, H - 1), $urandom_range(0, V - 1),
                             $urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0);
            else cyc(1, 0, -$urandom_range(1, 100), -$urandom_range(0, 40),
                     $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drain", drv_edge, 32'(pxq.size() + ptq.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
